// File: rtl/axi_pkg.sv
// Shared AXI4-Lite types and bus widths for the SRAM responder.
// Provides axi_resp_t plus address, data and strobe widths.
`ifndef YSYX_23060251_AXI_ADDR_BUS
`define YSYX_23060251_AXI_ADDR_BUS 32
`endif
`ifndef AXI_DATA_BUS
`define AXI_DATA_BUS 32
`endif
`ifndef AXI_STRB_BUS
`define AXI_STRB_BUS 4
`endif

package axi_pkg;
    localparam int AXI_ADDR_W = `YSYX_23060251_AXI_ADDR_BUS;
    localparam int AXI_DATA_W = `AXI_DATA_BUS;
    localparam int AXI_STRB_W = `AXI_STRB_BUS;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;
endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4-Lite bus bundle: AR/R read and AW/W/B write channels.
// master drives requests, slave drives readies and responses.
interface axi_sram_slave_if;
    import axi_pkg::*;

    logic                  ar_valid;
    logic [AXI_ADDR_W-1:0] ar_addr;
    logic                  ar_ready;
    logic                  r_valid;
    logic [AXI_DATA_W-1:0] r_data;
    axi_resp_t             r_resp;
    logic                  r_ready;
    logic                  aw_valid;
    logic [AXI_ADDR_W-1:0] aw_addr;
    logic                  aw_ready;
    logic                  w_valid;
    logic [AXI_DATA_W-1:0] w_data;
    logic [AXI_STRB_W-1:0] w_strb;
    logic                  w_ready;
    logic                  b_valid;
    axi_resp_t             b_resp;
    logic                  b_ready;

    modport master (
        output ar_valid, ar_addr, r_ready,
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
        input  ar_ready, r_valid, r_data, r_resp,
        input  aw_ready, w_ready, b_valid, b_resp
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready,
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
        output ar_ready, r_valid, r_data, r_resp,
        output aw_ready, w_ready, b_valid, b_resp
    );
endinterface

// File: rtl/sram_1rw_bytemask.sv
// Word-addressed SRAM: registered read port, byte-masked write port.
// Ports: clk_i, rst_i (async low), re_i/raddr_i/rdata_o, we_i/waddr_i/wdata_i/wmask_i.
module sram_1rw_bytemask #(
    parameter int WORDS = 4096,
    parameter int AW    = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    wmask_i
);
    logic [31:0] mem [WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Read samples the array before the same-edge write lands.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) rdata_d = mem[raddr_i];
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_sram_slave.sv
// AXI4-Lite SRAM responder with programmable read/write latency.
// Ports: clk_i, rst_i (async low), slv (axi_sram_slave_if.slave).
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int          MEM_WORDS  = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          RD_LATENCY = 2,
    parameter int          WR_LATENCY = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    axi_sram_slave_if.slave   slv
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [AXI_ADDR_W-1:0] SPAN = AXI_ADDR_W'(MEM_WORDS * 4);
    localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);
    localparam logic [3:0] WR_LAT = 4'(WR_LATENCY);

    typedef enum logic [2:0] {
        R_IDLE = 3'b001, R_WAIT = 3'b010, R_RESP = 3'b100
    } r_state_e;
    typedef enum logic [2:0] {
        W_IDLE = 3'b001, W_WAIT = 3'b010, W_RESP = 3'b100
    } w_state_e;

    // Unsigned wrap-around compare covers addresses below BASE_ADDR too.
    function automatic logic in_range(logic [AXI_ADDR_W-1:0] a);
        logic [AXI_ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return off < SPAN;
    endfunction

    function automatic logic [AW-1:0] word_idx(logic [AXI_ADDR_W-1:0] a);
        logic [AXI_ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return AW'(off >> 2);
    endfunction

    r_state_e    r_state_q, r_state_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic        r_err_q, r_err_d;
    logic        ar_ready_q, ar_ready_d;
    logic        r_valid_q, r_valid_d;
    logic        rd_go;
    logic [31:0] rd_addr;

    w_state_e    w_state_q, w_state_d;
    logic [3:0]  wr_cnt_q, wr_cnt_d;
    logic        aw_flag_q, aw_flag_d;
    logic        w_flag_q, w_flag_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        b_err_q, b_err_d;
    logic        aw_ready_q, aw_ready_d;
    logic        w_ready_q, w_ready_d;
    logic        b_valid_q, b_valid_d;
    logic        wr_go;

    logic [31:0] sram_rdata;

    // Read FSM: data is captured on the edge that enters R_RESP.
    always_comb begin
        r_state_d = r_state_q;
        rd_cnt_d  = rd_cnt_q;
        ar_addr_d = ar_addr_q;
        r_err_d   = r_err_q;
        rd_go     = 1'b0;
        rd_addr   = ar_addr_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (slv.ar_valid && ar_ready_q) begin
                    ar_addr_d = slv.ar_addr;
                    rd_cnt_d  = RD_LAT;
                    if (RD_LAT == 4'd0) begin
                        r_state_d = R_RESP;
                        rd_go     = 1'b1;
                        rd_addr   = slv.ar_addr;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                rd_cnt_d = rd_cnt_q - 4'd1;
                if (rd_cnt_q == 4'd1) begin
                    r_state_d = R_RESP;
                    rd_go     = 1'b1;
                end
            end
            R_RESP: begin
                if (slv.r_ready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rd_go) r_err_d = !in_range(rd_addr);
        ar_ready_d = (r_state_d == R_IDLE);
        r_valid_d  = (r_state_d == R_RESP);
    end

    // Write FSM: AW and W are captured independently; the commit
    // uses the _d view so a same-cycle capture is not missed.
    always_comb begin
        w_state_d = w_state_q;
        wr_cnt_d  = wr_cnt_q;
        aw_flag_d = aw_flag_q;
        w_flag_d  = w_flag_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_err_d   = b_err_q;
        wr_go     = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (slv.aw_valid && aw_ready_q) begin
                    aw_flag_d = 1'b1;
                    aw_addr_d = slv.aw_addr;
                end
                if (slv.w_valid && w_ready_q) begin
                    w_flag_d = 1'b1;
                    w_data_d = slv.w_data;
                    w_strb_d = slv.w_strb;
                end
                if (aw_flag_d && w_flag_d) begin
                    wr_cnt_d = WR_LAT;
                    if (WR_LAT == 4'd0) begin
                        w_state_d = W_RESP;
                        wr_go     = 1'b1;
                    end else begin
                        w_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                wr_cnt_d = wr_cnt_q - 4'd1;
                if (wr_cnt_q == 4'd1) begin
                    w_state_d = W_RESP;
                    wr_go     = 1'b1;
                end
            end
            W_RESP: begin
                if (slv.b_ready) begin
                    w_state_d = W_IDLE;
                    aw_flag_d = 1'b0;
                    w_flag_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (wr_go) b_err_d = !in_range(aw_addr_d);
        aw_ready_d = (w_state_d == W_IDLE) && !aw_flag_d;
        w_ready_d  = (w_state_d == W_IDLE) && !w_flag_d;
        b_valid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state_q  <= R_IDLE;
            rd_cnt_q   <= '0;
            ar_addr_q  <= '0;
            r_err_q    <= 1'b0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            w_state_q  <= W_IDLE;
            wr_cnt_q   <= '0;
            aw_flag_q  <= 1'b0;
            w_flag_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_err_q    <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            rd_cnt_q   <= rd_cnt_d;
            ar_addr_q  <= ar_addr_d;
            r_err_q    <= r_err_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            w_state_q  <= w_state_d;
            wr_cnt_q   <= wr_cnt_d;
            aw_flag_q  <= aw_flag_d;
            w_flag_q   <= w_flag_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_err_q    <= b_err_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
        end
    end

    sram_1rw_bytemask #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .re_i    (rd_go && in_range(rd_addr)),
        .raddr_i (word_idx(rd_addr)),
        .rdata_o (sram_rdata),
        .we_i    (wr_go && in_range(aw_addr_d)),
        .waddr_i (word_idx(aw_addr_d)),
        .wdata_i (w_data_d),
        .wmask_i (w_strb_d)
    );

    assign slv.ar_ready = ar_ready_q;
    assign slv.r_valid  = r_valid_q;
    assign slv.r_data   = r_err_q ? 32'h0 : sram_rdata;
    assign slv.r_resp   = r_err_q ? DECERR : OKAY;
    assign slv.aw_ready = aw_ready_q;
    assign slv.w_ready  = w_ready_q;
    assign slv.b_valid  = b_valid_q;
    assign slv.b_resp   = b_err_q ? DECERR : OKAY;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: vector table plus corner sequences.
// Expected R/B responses queue at issue and are popped on handshake.
module tb_axi_sram_slave;
    import axi_pkg::*;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_sram_slave_if bus();

    axi_sram_slave #(
        .MEM_WORDS  (4096),
        .BASE_ADDR  (32'h8000_0000),
        .RD_LATENCY (RD_LAT),
        .WR_LATENCY (WR_LAT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .slv   (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        axi_resp_t   resp;
    } r_exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        axi_resp_t   bresp;
        logic [31:0] rdata;
        axi_resp_t   rresp;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int r_hs = 0;
    int b_hs = 0;
    r_exp_t r_q[$];
    axi_resp_t b_q[$];
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, want %08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        r_exp_t e;
        if (rst_n && bus.r_valid && bus.r_ready) begin
            r_hs++;
            if (r_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL r_unexpected: got R beat, want none");
            end else begin
                e = r_q.pop_front();
                chk("r_data", bus.r_data, e.data);
                chk("r_resp", 32'(bus.r_resp), 32'(e.resp));
            end
        end
        if (rst_n && bus.b_valid && bus.b_ready) begin
            b_hs++;
            if (b_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_unexpected: got B beat, want none");
            end else begin
                chk("b_resp", 32'(bus.b_resp), 32'(b_q.pop_front()));
            end
        end
    end

    task automatic read_issue(input logic [31:0] a, input logic [31:0] d,
                              input axi_resp_t rs);
        int k = 0;
        r_exp_t e;
        bus.ar_valid = 1'b1;
        bus.ar_addr  = a;
        while (!bus.ar_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("ar_ready_timeout", 32'(k >= 50), 0);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        e.data = d;
        e.resp = rs;
        r_q.push_back(e);
    endtask

    task automatic read_wait(input int exp_lat);
        int lat = 1;
        while (!bus.r_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        chk("r_latency", lat, exp_lat);
        if (bus.r_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic write_issue(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input axi_resp_t rs,
                               input int aw_dly, input int w_dly);
        int k = 0;
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_f;
        bit w_f;
        while (!(aw_done && w_done) && k < 60) begin
            if (!aw_done && k >= aw_dly) begin
                bus.aw_valid = 1'b1;
                bus.aw_addr  = a;
            end
            if (!w_done && k >= w_dly) begin
                bus.w_valid = 1'b1;
                bus.w_data  = d;
                bus.w_strb  = s;
            end
            aw_f = bus.aw_valid && bus.aw_ready;
            w_f  = bus.w_valid && bus.w_ready;
            @(posedge clk); #1; k++;
            if (aw_f) begin bus.aw_valid = 1'b0; aw_done = 1; end
            if (w_f)  begin bus.w_valid = 1'b0;  w_done = 1;  end
        end
        chk("aw_w_timeout", 32'(!(aw_done && w_done)), 0);
        b_q.push_back(rs);
    endtask

    task automatic write_wait(input int exp_lat);
        int lat = 1;
        while (!bus.b_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        chk("b_latency", lat, exp_lat);
        if (bus.b_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int b0;
        tbl[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, OKAY, 32'hDEAD_BEEF, OKAY};
        tbl[1] = '{1'b1, 32'h8000_0000, 32'h1122_3344, 4'hF, OKAY, 32'h1122_3344, OKAY};
        tbl[2] = '{1'b1, 32'h8000_0004, 32'hCAFE_F00D, 4'hF, OKAY, 32'hCAFE_F00D, OKAY};
        tbl[3] = '{1'b1, 32'h8000_3FFC, 32'h0123_4567, 4'hF, OKAY, 32'h0123_4567, OKAY};
        tbl[4] = '{1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h0, OKAY, 32'hCAFE_F00D, OKAY};
        tbl[5] = '{1'b1, 32'h8000_0006, 32'h0000_00AA, 4'h1, OKAY, 32'hCAFE_F0AA, OKAY};
        tbl[6] = '{1'b1, 32'h8000_4000, 32'h5555_5555, 4'hF, DECERR, 32'h0, DECERR};
        tbl[7] = '{1'b1, 32'h7FFF_FFFC, 32'h6666_6666, 4'hF, DECERR, 32'h0, DECERR};
        tbl[8] = '{1'b1, 32'h8000_3FFC, 32'hAB00_0000, 4'h8, OKAY, 32'hAB23_4567, OKAY};
        tbl[9] = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, OKAY, 32'h1122_3344, OKAY};

        bus.ar_valid = 0; bus.ar_addr = 0; bus.r_ready = 1;
        bus.aw_valid = 0; bus.aw_addr = 0;
        bus.w_valid = 0;  bus.w_data = 0;  bus.w_strb = 0;
        bus.b_ready = 1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ar_ready", 32'(bus.ar_ready), 0);
        chk("rst_aw_ready", 32'(bus.aw_ready), 0);
        chk("rst_w_ready", 32'(bus.w_ready), 0);
        chk("rst_r_valid", 32'(bus.r_valid), 0);
        chk("rst_b_valid", 32'(bus.b_valid), 0);
        chk("rst_r_data", bus.r_data, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ar_ready", 32'(bus.ar_ready), 1);
        chk("rel_aw_ready", 32'(bus.aw_ready), 1);
        chk("rel_w_ready", 32'(bus.w_ready), 1);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) begin
                write_issue(tbl[i].addr, tbl[i].wdata, tbl[i].strb,
                            tbl[i].bresp, 0, 0);
                write_wait(WR_LAT + 1);
            end
            read_issue(tbl[i].addr, tbl[i].rdata, tbl[i].rresp);
            read_wait(RD_LAT + 1);
        end

        // W leads AW by two cycles; one B, merged bytes.
        b0 = b_hs;
        write_issue(32'h8000_0000, 32'hAABB_CCDD, 4'b0101, OKAY, 2, 0);
        write_wait(WR_LAT + 1);
        chk("partial_b_count", b_hs - b0, 1);
        read_issue(32'h8000_0000, 32'h11BB_33DD, OKAY);
        read_wait(RD_LAT + 1);

        // Backpressure on R and B.
        r0 = r_hs;
        b0 = b_hs;
        bus.r_ready = 0;
        bus.b_ready = 0;
        read_issue(32'h8000_0010, 32'hDEAD_BEEF, OKAY);
        read_wait(RD_LAT + 1);
        write_issue(32'h8000_0008, 32'h5A5A_5A5A, 4'hF, OKAY, 0, 0);
        write_wait(WR_LAT + 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_r_valid", 32'(bus.r_valid), 1);
            chk("bp_r_data", bus.r_data, 32'hDEAD_BEEF);
            chk("bp_b_valid", 32'(bus.b_valid), 1);
            chk("bp_b_resp", 32'(bus.b_resp), 32'(OKAY));
            chk("bp_ar_ready", 32'(bus.ar_ready), 0);
            chk("bp_aw_ready", 32'(bus.aw_ready), 0);
        end
        bus.r_ready = 1;
        bus.b_ready = 1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("bp_r_count", r_hs - r0, 1);
        chk("bp_b_count", b_hs - b0, 1);
        chk("bp_ar_ready_back", 32'(bus.ar_ready), 1);
        read_issue(32'h8000_0008, 32'h5A5A_5A5A, OKAY);
        read_wait(RD_LAT + 1);

        // Read capture and write commit on the same edge.
        write_issue(32'h8000_0020, 32'h0101_0101, 4'hF, OKAY, 0, 0);
        write_wait(WR_LAT + 1);
        fork
            read_issue(32'h8000_0020, 32'h0101_0101, OKAY);
            write_issue(32'h8000_0020, 32'h0202_0202, 4'hF, OKAY, 0, 0);
        join
        fork
            read_wait(RD_LAT + 1);
            write_wait(WR_LAT + 1);
        join
        read_issue(32'h8000_0020, 32'h0202_0202, OKAY);
        read_wait(RD_LAT + 1);

        // Reset during R_WAIT abandons the read.
        read_issue(32'h8000_0010, 32'hDEAD_BEEF, OKAY);
        r0 = r_hs;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_r_valid", 32'(bus.r_valid), 0);
        chk("mid_rst_ar_ready", 32'(bus.ar_ready), 0);
        chk("mid_rst_aw_ready", 32'(bus.aw_ready), 0);
        chk("mid_rst_w_ready", 32'(bus.w_ready), 0);
        void'(r_q.pop_back());
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_rst_no_r", r_hs - r0, 0);
        chk("mid_rst_ar_ready_back", 32'(bus.ar_ready), 1);
        read_issue(32'h8000_0010, 32'hDEAD_BEEF, OKAY);
        read_wait(RD_LAT + 1);

        repeat (4) @(posedge clk);
        #1;
        chk("r_q_drained", r_q.size(), 0);
        chk("b_q_drained", b_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
